// File: rtl/stage_mem.sv
// Memory-access stage: runs word LOAD/STORE on the shared bus, checks alignment and loads the MEM/WB register.
// Minimum access takes 4 cycles (busy high for 3); busy stalls the pipeline until bus_rdy_ completes the access.
module stage_mem #(
  parameter int WORD_W      = 32,
  parameter int WORD_ADDR_W = 30,
  parameter int GPR_ADDR_W  = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  output logic                   busy,
  output logic [WORD_W-1:0]      fwd_data,
  input  logic [WORD_ADDR_W-1:0] ex_pc,
  input  logic                   ex_en,
  input  logic                   ex_br_flag,
  input  logic [1:0]             ex_mem_op,
  input  logic [WORD_W-1:0]      ex_mem_wr_data,
  input  logic [1:0]             ex_ctrl_op,
  input  logic [GPR_ADDR_W-1:0]  ex_dst_addr,
  input  logic                   ex_gpr_we_,
  input  logic [2:0]             ex_exp_code,
  input  logic [WORD_W-1:0]      ex_out,
  output logic                   bus_req,
  input  logic                   bus_grant,
  output logic                   bus_as_,
  output logic                   bus_rw,
  output logic [WORD_ADDR_W-1:0] bus_addr,
  output logic [WORD_W-1:0]      bus_wr_data,
  input  logic [WORD_W-1:0]      bus_rd_data,
  input  logic                   bus_rdy_,
  output logic [WORD_ADDR_W-1:0] mem_pc,
  output logic                   mem_en,
  output logic                   mem_br_flag,
  output logic [1:0]             mem_ctrl_op,
  output logic [GPR_ADDR_W-1:0]  mem_dst_addr,
  output logic                   mem_gpr_we_,
  output logic [2:0]             mem_exp_code,
  output logic [WORD_W-1:0]      mem_out
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'd1;
  localparam logic [1:0] OP_STORE = 2'd2;

  localparam logic [2:0] EXP_MISALIGN = 3'd4;

  logic [1:0]             state_q, state_d;
  logic                   flush_pend_q, flush_pend_d;
  logic                   bus_req_q, bus_req_d;
  logic                   bus_as_q, bus_as_d;
  logic                   bus_rw_q, bus_rw_d;
  logic [WORD_ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [WORD_W-1:0]      bus_wr_data_q, bus_wr_data_d;
  logic [WORD_ADDR_W-1:0] mem_pc_q, mem_pc_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_br_flag_q, mem_br_flag_d;
  logic [1:0]             mem_ctrl_op_q, mem_ctrl_op_d;
  logic [GPR_ADDR_W-1:0]  mem_dst_addr_q, mem_dst_addr_d;
  logic                   mem_gpr_we_q, mem_gpr_we_d;
  logic [2:0]             mem_exp_code_q, mem_exp_code_d;
  logic [WORD_W-1:0]      mem_out_q, mem_out_d;

  logic need, misalign, go, is_load, mem_upd;

  always_comb begin
    is_load  = (ex_mem_op == OP_LOAD);
    need     = ex_en && (ex_exp_code == 3'd0) && (is_load || ex_mem_op == OP_STORE);
    misalign = need && (ex_out[1:0] != 2'b00);
    go       = need && !misalign;

    busy = ((state_q == ST_IDLE) && go && !flush) ||
           ((state_q == ST_REQ) && !flush) ||
           (state_q == ST_ACCESS) ||
           ((state_q == ST_WAIT) && bus_rdy_);

    fwd_data = ((state_q == ST_WAIT) && is_load) ? bus_rd_data : ex_out;
    mem_upd  = !stall && !busy;

    // Bus strobes are computed from the next state so they line up with the state they name.
    state_d       = state_q;
    bus_req_d     = bus_req_q;
    bus_as_d      = bus_as_q;
    bus_rw_d      = bus_rw_q;
    bus_addr_d    = bus_addr_q;
    bus_wr_data_d = bus_wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (go && !flush) begin
          state_d   = ST_REQ;
          bus_req_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (flush) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end else if (bus_grant) begin
          state_d       = ST_ACCESS;
          bus_as_d      = 1'b0;
          bus_addr_d    = ex_out[WORD_ADDR_W+1:2];
          bus_rw_d      = is_load;
          bus_wr_data_d = ex_mem_wr_data;
        end
      end
      ST_ACCESS: begin
        state_d  = ST_WAIT;
        bus_as_d = 1'b1;
      end
      default: begin
        if (!bus_rdy_) begin
          state_d   = ST_IDLE;
          bus_req_d = 1'b0;
        end
      end
    endcase

    // A flush cannot abort a started access; remember it and bubble on completion.
    flush_pend_d = flush_pend_q;
    if (mem_upd)
      flush_pend_d = 1'b0;
    else if (flush && (state_q == ST_ACCESS || state_q == ST_WAIT))
      flush_pend_d = 1'b1;

    mem_pc_d       = mem_pc_q;
    mem_en_d       = mem_en_q;
    mem_br_flag_d  = mem_br_flag_q;
    mem_ctrl_op_d  = mem_ctrl_op_q;
    mem_dst_addr_d = mem_dst_addr_q;
    mem_gpr_we_d   = mem_gpr_we_q;
    mem_exp_code_d = mem_exp_code_q;
    mem_out_d      = mem_out_q;
    if (mem_upd) begin
      if (flush || flush_pend_q) begin
        mem_pc_d       = '0;
        mem_en_d       = 1'b0;
        mem_br_flag_d  = 1'b0;
        mem_ctrl_op_d  = 2'd0;
        mem_dst_addr_d = '0;
        mem_gpr_we_d   = 1'b1;
        mem_exp_code_d = 3'd0;
        mem_out_d      = '0;
      end else begin
        mem_pc_d      = ex_pc;
        mem_en_d      = ex_en;
        mem_br_flag_d = ex_br_flag;
        if (misalign) begin
          mem_ctrl_op_d  = 2'd0;
          mem_dst_addr_d = ex_dst_addr;
          mem_gpr_we_d   = 1'b1;
          mem_exp_code_d = EXP_MISALIGN;
          mem_out_d      = '0;
        end else begin
          mem_ctrl_op_d  = ex_ctrl_op;
          mem_dst_addr_d = ex_dst_addr;
          mem_gpr_we_d   = ex_gpr_we_;
          mem_exp_code_d = ex_exp_code;
          mem_out_d      = fwd_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      flush_pend_q   <= 1'b0;
      bus_req_q      <= 1'b0;
      bus_as_q       <= 1'b1;
      bus_rw_q       <= 1'b1;
      bus_addr_q     <= '0;
      bus_wr_data_q  <= '0;
      mem_pc_q       <= '0;
      mem_en_q       <= 1'b0;
      mem_br_flag_q  <= 1'b0;
      mem_ctrl_op_q  <= 2'd0;
      mem_dst_addr_q <= '0;
      mem_gpr_we_q   <= 1'b1;
      mem_exp_code_q <= 3'd0;
      mem_out_q      <= '0;
    end else begin
      state_q        <= state_d;
      flush_pend_q   <= flush_pend_d;
      bus_req_q      <= bus_req_d;
      bus_as_q       <= bus_as_d;
      bus_rw_q       <= bus_rw_d;
      bus_addr_q     <= bus_addr_d;
      bus_wr_data_q  <= bus_wr_data_d;
      mem_pc_q       <= mem_pc_d;
      mem_en_q       <= mem_en_d;
      mem_br_flag_q  <= mem_br_flag_d;
      mem_ctrl_op_q  <= mem_ctrl_op_d;
      mem_dst_addr_q <= mem_dst_addr_d;
      mem_gpr_we_q   <= mem_gpr_we_d;
      mem_exp_code_q <= mem_exp_code_d;
      mem_out_q      <= mem_out_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_as_      = bus_as_q;
  assign bus_rw       = bus_rw_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wr_data  = bus_wr_data_q;
  assign mem_pc       = mem_pc_q;
  assign mem_en       = mem_en_q;
  assign mem_br_flag  = mem_br_flag_q;
  assign mem_ctrl_op  = mem_ctrl_op_q;
  assign mem_dst_addr = mem_dst_addr_q;
  assign mem_gpr_we_  = mem_gpr_we_q;
  assign mem_exp_code = mem_exp_code_q;
  assign mem_out      = mem_out_q;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: load, store, misalign, flush, exception pass-through, stall and reset.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        busy;
  logic [31:0] fwd_data;
  logic [29:0] ex_pc;
  logic        ex_en, ex_br_flag;
  logic [1:0]  ex_mem_op, ex_ctrl_op;
  logic [31:0] ex_mem_wr_data, ex_out;
  logic [4:0]  ex_dst_addr;
  logic        ex_gpr_we_;
  logic [2:0]  ex_exp_code;
  logic        bus_req, bus_grant, bus_as_, bus_rw, bus_rdy_;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data, bus_rd_data;
  logic [29:0] mem_pc;
  logic        mem_en, mem_br_flag, mem_gpr_we_;
  logic [1:0]  mem_ctrl_op;
  logic [4:0]  mem_dst_addr;
  logic [2:0]  mem_exp_code;
  logic [31:0] mem_out;

  int checks = 0;
  int errors = 0;
  int as_cnt = 0;
  int as_start;

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_as_ === 1'b0) as_cnt <= as_cnt + 1;

  stage_mem dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy), .fwd_data(fwd_data),
    .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_ctrl_op(ex_ctrl_op), .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_out(ex_out),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_as_(bus_as_), .bus_rw(bus_rw),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_),
    .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag), .mem_ctrl_op(mem_ctrl_op),
    .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
    .mem_out(mem_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic en, input logic [1:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] exp);
    ex_en = en; ex_mem_op = op; ex_out = addr; ex_mem_wr_data = wdata; ex_exp_code = exp;
    ex_pc = 30'h123; ex_br_flag = 1'b1; ex_ctrl_op = 2'd2; ex_dst_addr = 5'd3; ex_gpr_we_ = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b want 0", bus_req); end
    checks++; if (bus_as_ !== 1'b1) begin errors++; $display("FAIL reset_bus_as_: got %b want 1", bus_as_); end
    checks++; if (bus_rw !== 1'b1) begin errors++; $display("FAIL reset_bus_rw: got %b want 1", bus_rw); end
    checks++; if (bus_addr !== 30'd0 || bus_wr_data !== 32'd0) begin errors++; $display("FAIL reset_bus_addr_data: got %h/%h want 0/0", bus_addr, bus_wr_data); end
    checks++; if (mem_gpr_we_ !== 1'b1 || mem_en !== 1'b0 || mem_out !== 32'd0 || mem_pc !== 30'd0) begin
      errors++; $display("FAIL reset_mem: got we_=%b en=%b out=%h pc=%h want 1/0/0/0", mem_gpr_we_, mem_en, mem_out, mem_pc); end
    checks++; if (mem_exp_code !== 3'd0 || mem_ctrl_op !== 2'd0 || mem_dst_addr !== 5'd0 || mem_br_flag !== 1'b0) begin
      errors++; $display("FAIL reset_mem_ctrl: got exp=%0d ctrl=%0d dst=%0d br=%b want 0", mem_exp_code, mem_ctrl_op, mem_dst_addr, mem_br_flag); end
  endtask

  task automatic test_load();
    bus_grant = 1'b1; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
    set_ex(1'b1, 2'd1, 32'h100, 32'h0, 3'd0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_busy_idle: got %b want 1", busy); end
    tick();
    checks++; if (bus_req !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL load_req: got req=%b as_=%b busy=%b want 1/1/1", bus_req, bus_as_, busy); end
    tick();
    checks++; if (bus_as_ !== 1'b0 || bus_addr !== 30'h40 || bus_rw !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL load_access: got as_=%b addr=%h rw=%b busy=%b want 0/40/1/1", bus_as_, bus_addr, bus_rw, busy); end
    tick();
    checks++; if (bus_as_ !== 1'b1 || bus_req !== 1'b1 || busy !== 1'b0 || fwd_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_wait: got as_=%b req=%b busy=%b fwd=%h want 1/1/0/deadbeef", bus_as_, bus_req, busy, fwd_data); end
    tick();
    set_ex(1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
    checks++; if (mem_out !== 32'hDEADBEEF || mem_en !== 1'b1 || mem_dst_addr !== 5'd3 || mem_gpr_we_ !== 1'b0 || bus_req !== 1'b0) begin
      errors++; $display("FAIL load_result: got out=%h en=%b dst=%0d we_=%b req=%b want deadbeef/1/3/0/0", mem_out, mem_en, mem_dst_addr, mem_gpr_we_, bus_req); end
    tick();
  endtask

  task automatic test_store();
    bus_grant = 1'b0; bus_rdy_ = 1'b1; as_start = as_cnt;
    set_ex(1'b1, 2'd2, 32'h204, 32'h1234, 3'd0);
    tick(); tick(); tick();
    checks++; if (bus_req !== 1'b1 || bus_as_ !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL store_req_wait: got req=%b as_=%b busy=%b want 1/1/1", bus_req, bus_as_, busy); end
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    checks++; if (bus_as_ !== 1'b0 || bus_rw !== 1'b0 || bus_wr_data !== 32'h1234 || bus_addr !== 30'h81) begin
      errors++; $display("FAIL store_access: got as_=%b rw=%b wd=%h addr=%h want 0/0/1234/81", bus_as_, bus_rw, bus_wr_data, bus_addr); end
    tick(); tick();
    checks++; if (busy !== 1'b1 || bus_req !== 1'b1) begin errors++; $display("FAIL store_wait_busy: got busy=%b req=%b want 1/1", busy, bus_req); end
    bus_rdy_ = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL store_rdy_busy: got %b want 0", busy); end
    tick();
    set_ex(1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
    checks++; if (mem_out !== 32'h204 || as_cnt - as_start != 1) begin errors++; $display("FAIL store_result: got out=%h as_pulses=%0d want 204/1", mem_out, as_cnt - as_start); end
    tick();
  endtask

  task automatic test_misalign();
    set_ex(1'b1, 2'd1, 32'h102, 32'h0, 3'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL misalign_busy: got %b want 0", busy); end
    tick();
    checks++; if (bus_req !== 1'b0 || mem_exp_code !== 3'd4 || mem_gpr_we_ !== 1'b1 || mem_out !== 32'd0 || mem_pc !== 30'h123 || mem_ctrl_op !== 2'd0) begin
      errors++; $display("FAIL misalign_result: got req=%b exp=%0d we_=%b out=%h pc=%h ctrl=%0d want 0/4/1/0/123/0", bus_req, mem_exp_code, mem_gpr_we_, mem_out, mem_pc, mem_ctrl_op); end
    set_ex(1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
    tick();
  endtask

  task automatic test_flush_req();
    bus_grant = 1'b0; bus_rdy_ = 1'b1; as_start = as_cnt;
    set_ex(1'b1, 2'd1, 32'h300, 32'h0, 3'd0);
    tick();
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL flush_req_pre: got %b want 1", bus_req); end
    flush = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_req_busy: got %b want 0", busy); end
    tick();
    flush = 1'b0;
    set_ex(1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
    checks++; if (bus_req !== 1'b0 || mem_en !== 1'b0 || mem_gpr_we_ !== 1'b1 || mem_pc !== 30'd0 || as_cnt != as_start) begin
      errors++; $display("FAIL flush_req_result: got req=%b en=%b we_=%b pc=%h as_pulses=%0d want 0/0/1/0/0", bus_req, mem_en, mem_gpr_we_, mem_pc, as_cnt - as_start); end
    tick();
  endtask

  task automatic test_flush_wait();
    bus_grant = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = 32'hCAFEF00D;
    set_ex(1'b1, 2'd1, 32'h400, 32'h0, 3'd0);
    tick(); tick(); tick(); tick();
    flush = 1'b1; #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_wait_busy: got %b want 1", busy); end
    tick();
    flush = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b1 || bus_req !== 1'b1) begin errors++; $display("FAIL flush_wait_hold: got busy=%b req=%b want 1/1", busy, bus_req); end
    bus_rdy_ = 1'b0;
    tick();
    set_ex(1'b1, 2'd0, 32'h55, 32'h0, 3'd0);
    checks++; if (mem_en !== 1'b0 || mem_out !== 32'd0 || mem_gpr_we_ !== 1'b1 || bus_req !== 1'b0) begin
      errors++; $display("FAIL flush_wait_bubble: got en=%b out=%h we_=%b req=%b want 0/0/1/0", mem_en, mem_out, mem_gpr_we_, bus_req); end
    tick();
    checks++; if (mem_out !== 32'h55 || mem_en !== 1'b1) begin errors++; $display("FAIL flush_pend_clear: got out=%h en=%b want 55/1", mem_out, mem_en); end
  endtask

  task automatic test_exp_code_stall();
    set_ex(1'b1, 2'd1, 32'h500, 32'h0, 3'd3);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exp_busy: got %b want 0", busy); end
    tick();
    checks++; if (bus_req !== 1'b0 || mem_exp_code !== 3'd3 || mem_out !== 32'h500) begin
      errors++; $display("FAIL exp_result: got req=%b exp=%0d out=%h want 0/3/500", bus_req, mem_exp_code, mem_out); end
    stall = 1'b1;
    set_ex(1'b1, 2'd0, 32'h77, 32'h0, 3'd0);
    tick();
    checks++; if (mem_out !== 32'h500 || mem_exp_code !== 3'd3) begin errors++; $display("FAIL stall_hold: got out=%h exp=%0d want 500/3", mem_out, mem_exp_code); end
    stall = 1'b0;
    tick();
    checks++; if (mem_out !== 32'h77) begin errors++; $display("FAIL stall_release: got %h want 77", mem_out); end
  endtask

  task automatic test_reset_in_wait();
    bus_grant = 1'b1; bus_rdy_ = 1'b1;
    set_ex(1'b1, 2'd2, 32'h600, 32'hABCD, 3'd0);
    tick(); tick(); tick();
    checks++; if (bus_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_wait_pre: got req=%b busy=%b want 1/1", bus_req, busy); end
    reset = 1'b1;
    tick();
    test_reset();
    reset = 1'b0;
    set_ex(1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_wait_idle: got busy=%b want 0", busy); end
    tick();
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_wait_after: got req=%b want 0", bus_req); end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    bus_grant = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = 32'h0;
    set_ex(1'b0, 2'd0, 32'h0, 32'h0, 3'd0);
    tick(); tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_load();
    test_store();
    test_misalign();
    test_flush_req();
    test_flush_wait();
    test_exp_code_stall();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
